// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types for the dmem load/store controller: access sizes, FSM states
// and the bus widths.
package dmem_lsu_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_LD_WAIT = 2'd1,
    LSU_RMW_WR  = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_e;

  // The unused size code 3 behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response channel from the memory stage plus the dmem port.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; valid must not drop before that edge.
interface dmem_lsu_ctrl_if;
  import dmem_lsu_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [ADDR_LEN-1:0] req_addr;
  logic [DATA_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_rdata;
  logic                resp_err;
  logic [ADDR_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;
  logic                dmem_we;
  logic [DATA_LEN-1:0] dmem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dmem_addr, dmem_wdata, dmem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dmem_addr, dmem_wdata, dmem_we
  );

endinterface

// File: rtl/dmem_lsu_ctrl_byte_lane.sv
// Byte-lane unit: extracts and extends load data from a dmem word and merges
// byte/half store data into a dmem word for read-modify-write.
module dmem_lsu_ctrl_byte_lane
  import dmem_lsu_ctrl_pkg::*;
(
  input  logic [DATA_LEN-1:0] word_i,
  input  logic [1:0]          off_i,
  input  size_e               size_i,
  input  logic                unsigned_i,
  input  logic [15:0]         wdata_i,
  output logic [DATA_LEN-1:0] load_o,
  output logic [DATA_LEN-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      default: ;  // word stores bypass the merge path
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Initiator for the single-port data BRAM: loads, word stores and byte/half
// read-modify-write stores. DMEM_MISALIGN_CHK_EN enables misalignment errors.
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  dmem_lsu_ctrl_if.slave bus,
  output lsu_state_e     state_dbg_o
);

  lsu_state_e          state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_LEN-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  size_e               req_sz;
  logic [1:0]          req_off;
  logic                req_mis;
  logic [DATA_LEN-1:0] lane_load, lane_merge;
  logic                req_ready_c, dmem_we_c;
  logic [ADDR_LEN-1:0] dmem_addr_c;
  logic [DATA_LEN-1:0] dmem_wdata_c;

  always_comb begin
    req_sz  = norm_size(bus.req_size);
    req_off = bus.req_addr[1:0];
`ifdef DMEM_MISALIGN_CHK_EN
    req_mis = ((req_sz == SZ_HALF) && req_off[0]) ||
              ((req_sz == SZ_WORD) && (req_off != 2'b00));
`else
    req_mis = 1'b0;
    if (req_sz == SZ_HALF)      req_off[0] = 1'b0;
    else if (req_sz == SZ_WORD) req_off    = 2'b00;
`endif
  end

  dmem_lsu_ctrl_byte_lane u_lane (
    .word_i     (bus.dmem_rdata),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready_c  = 1'b0;
    dmem_we_c    = 1'b0;
    dmem_wdata_c = '0;
    dmem_addr_c  = {2'b00, addr_q[ADDR_LEN-1:2]};

    case (state_q)
      LSU_IDLE: begin
        req_ready_c = 1'b1;
        dmem_addr_c = {2'b00, bus.req_addr[ADDR_LEN-1:2]};
        if (bus.req_valid) begin
          addr_d  = {bus.req_addr[ADDR_LEN-1:2], req_off};
          size_d  = req_sz;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata[15:0];
          if (req_mis) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            state_d      = LSU_RESP;
          end else if (!bus.req_we) begin
            state_d = LSU_LD_WAIT;
          end else if (req_sz == SZ_WORD) begin
            dmem_we_c    = 1'b1;
            dmem_wdata_c = bus.req_wdata;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            state_d      = LSU_RESP;
          end else begin
            // Sub-word store: this cycle is the read half of the RMW.
            state_d = LSU_RMW_WR;
          end
        end
      end
      LSU_LD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = lane_load;
        resp_err_d   = 1'b0;
        state_d      = LSU_RESP;
      end
      LSU_RMW_WR: begin
        dmem_we_c    = 1'b1;
        dmem_wdata_c = lane_merge;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = LSU_RESP;
      end
      default: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = LSU_IDLE;
        end
      end
    endcase

    // While reset is held the dmem port must be quiet, including the
    // combinational IDLE paths.
    if (!reset_n) begin
      dmem_we_c    = 1'b0;
      dmem_addr_c  = '0;
      dmem_wdata_c = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LSU_IDLE;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.dmem_addr  = dmem_addr_c;
  assign bus.dmem_wdata = dmem_wdata_c;
  assign bus.dmem_we    = dmem_we_c;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: BRAM model, reference memory, expected-response
// queue, directed plan cases and random traffic. Honours DMEM_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module tb_dmem_lsu_ctrl;
  import dmem_lsu_ctrl_pkg::*;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  lsu_state_e state_dbg;

  always #5 clk = ~clk;

  dmem_lsu_ctrl_if bus();

  dmem_lsu_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- BRAM model and reference ----------------
  logic [31:0]  mem [64];
  logic [31:0]  ref_mem [64];
  logic [31:0]  rdata_q;
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           we_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 4) return 32'h8877_6655;
    if (i == 8) return 32'h1122_3344;
    return {b ^ 8'hA5, b, 8'h3C, b + 8'd1};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.dmem_we) begin
      mem[bus.dmem_addr[5:0]] <= bus.dmem_wdata;
    end
    rdata_q <= mem[bus.dmem_addr[5:0]];
    if (bus.dmem_we) we_cnt <= we_cnt + 1;
  end

  assign bus.dmem_rdata = rdata_q;

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] ref_off(input logic [1:0] sz, input logic [31:0] a);
    logic [1:0] o;
    o = a[1:0];
`ifndef DMEM_MISALIGN_CHK_EN
    if (sz == 2'd1) o[0] = 1'b0;
    else if (sz >= 2'd2) o = 2'b00;
`endif
    return o;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] o);
    logic [31:0] v;
    v = w >> (8 * o);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] o, input logic [31:0] d);
    logic [31:0] m;
    m = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * o);
    return (w & ~m) | ((d << (8 * o)) & m);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall);
    logic [5:0]   idx;
    logic [1:0]   o;
    logic         mis;
    logic [31:0]  word, exp_r, exp_w;
    logic [W-1:0] exp_v;
    int           exp_lat, exp_we, we0, lat;

    idx   = addr[7:2];
    o     = ref_off(sz, addr);
    mis   = ref_misaligned(sz, addr);
    word  = ref_mem[idx];
    exp_r = 32'h0;
    exp_w = word;
    exp_we = 0;
    if (mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      exp_r   = ref_load(word, sz, uns, o);
    end else if (sz >= 2'd2) begin
      exp_lat = 1;
      exp_we  = 1;
      exp_w   = wd;
      ref_mem[idx] = wd;
    end else begin
      exp_lat = 2;
      exp_we  = 1;
      exp_w   = ref_merge(word, sz, o, wd);
      ref_mem[idx] = exp_w;
    end
    exp_q.push_back({mis, exp_r});

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    #1;
    check("req_ready_idle", bus.req_ready, 1);
    check("dmem_addr_req", bus.dmem_addr, {2'b00, addr[31:2]});
    check("dmem_we_req", bus.dmem_we, (exp_we == 1) && (exp_lat == 1));
    if (we && (exp_lat == 1) && !mis) check("wstore_wdata", bus.dmem_wdata, wd);
    we0 = we_cnt;

    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    #1;
    if (we && (exp_lat == 2)) begin
      check("rmw_we", bus.dmem_we, 1);
      check("rmw_addr", bus.dmem_addr, {2'b00, addr[31:2]});
      check("rmw_wdata", bus.dmem_wdata, exp_w);
    end
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    exp_v = exp_q.pop_front();
    if (!bus.resp_valid) begin
      check("resp_timeout", 0, 1);
      return;
    end
    check("latency", lat, exp_lat);

    for (int s = 0; s < stall; s++) begin
      check("stall_hold", {bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata},
            {2'b10, exp_v});
      @(negedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    check("resp", {bus.resp_err, bus.resp_rdata}, exp_v);
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    check("post_hs_valid", bus.resp_valid, 0);
    check("post_hs_ready", bus.req_ready, 1);
    check("we_pulses", we_cnt - we0, exp_we);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0040;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    #1;
    check("rst_state", state_dbg, LSU_IDLE);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_dmem_we", bus.dmem_we, 0);
    check("rst_dmem_addr", bus.dmem_addr, 0);
    check("rst_dmem_wdata", bus.dmem_wdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);          // word load
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);          // signed byte
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1);          // unsigned byte
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFAB, 0);  // byte RMW
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_BEEF, 0);  // half RMW
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5);          // long stall
    do_req(1'b0, 2'd3, 1'b1, 32'h10, 32'h0, 0);          // size 3 as word
    do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFE_F00D, 0);  // misaligned word store
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 0);          // misaligned half load

    for (int n = 0; n < 40; n++) begin
      do_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 3));
    end

    // Reset while a byte store sits in RMW_WR.
    begin
      int we0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd0;
      bus.req_addr  = 32'h05;
      bus.req_wdata = 32'h77;
      we0 = we_cnt;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      check("pre_rst_state", state_dbg, LSU_RMW_WR);
      reset_n = 1'b0;
      #1;
      check("mid_rst_state", state_dbg, LSU_IDLE);
      check("mid_rst_we", bus.dmem_we, 0);
      check("mid_rst_addr", bus.dmem_addr, 0);
      check("mid_rst_wdata", bus.dmem_wdata, 0);
      check("mid_rst_valid", bus.resp_valid, 0);
      check("mid_rst_rdata", bus.resp_rdata, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_no_we", we_cnt - we0, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      @(negedge clk);
      #1;
      check("post_rst_valid", bus.resp_valid, 0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Initiator side of the single-port data BRAM (dmem) interface.
- Accepts byte-addressed load/store requests from the memory pipeline stage over a valid/ready handshake.
- Translates each request to a word-addressed dmem access.
- Implements byte and halfword stores as read-modify-write, since dmem writes whole words only. Returns aligned, extended load data over a valid/ready response channel.

Parameters:
- ADDR_LEN, 32 (from constants.vh): request and dmem address width.
- DATA_LEN, 32 (from constants.vh): data width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_LEN  byte address
- req_wdata  in  DATA_LEN  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_LEN  load result; 0 for stores
- resp_err  out  1  misaligned access
- dmem_addr  out  ADDR_LEN  word address (req_addr >> 2)
- dmem_wdata  out  DATA_LEN  dmem write data
- dmem_we  out  1  dmem write enable
- dmem_rdata  in  DATA_LEN  dmem read data; valid one cycle after address

Behaviour:
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, dmem_we=0, dmem_addr=0, dmem_wdata=0. Held request registers clear to 0.
- States: IDLE, LD_WAIT, RMW_WR, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
- In IDLE, dmem_addr is driven combinationally from req_addr[ADDR_LEN-1:2]. In all other states it comes from the held address.
- Load accepted in cycle N:
  - go to LD_WAIT;
  - in N+1, select lane from dmem_rdata by addr[1:0], extend per size/unsigned, register it, go to RESP;
  - resp_valid=1 from N+2.
- Word store accepted in cycle N:
  - dmem_we=1, dmem_wdata=req_wdata combinationally in N;
  - go to RESP; resp_valid=1 from N+1.
- Byte/half store accepted in cycle N:
  - N is a read; go to RMW_WR;
  - in N+1, merge held wdata into dmem_rdata lanes per addr[1:0], assert dmem_we with the held address, go to RESP;
  - resp_valid=1 from N+2.
- RESP: hold resp_* stable until resp_ready=1, then return to IDLE. No new request is accepted in the same cycle as resp_ready; the next request is accepted in the following cycle at the earliest.
- Lane rules:
  - byte lane k = bits 8k+7:8k;
  - half at addr[1]=0 is bits 15:0, at addr[1]=1 is bits 31:16;
  - unused wdata bits are ignored.
- dmem_we is high for exactly one cycle per store and never for loads.
- Address range: no range check. Word address bits above dmem depth are passed through unchanged.
- Reset mid-operation: abort immediately, including any RMW in progress. No dmem_we pulse occurs after reset is asserted.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned;
  - no dmem access, dmem_we stays 0;
  - resp_err=1, resp_rdata=0, resp_valid from N+1.
- Undefined:
  - low address bits are forced to alignment (half clears bit0, word clears bits 1:0);
  - the access proceeds normally; resp_err is tied 0.

Decomposition:
- constants.vh gains:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings LSU_IDLE/LSU_LD_WAIT/LSU_RMW_WR/LSU_RESP.
- One combinational sub-module, dmem_byte_lane: load extract/extend and store merge (inputs word, addr[1:0], size, unsigned, wdata).
- Top module holds the FSM and registers.

Test Plan:
- Load word addr 0x10 with mem[4]=0x8877_6655 → dmem_addr=4 in N; resp_valid at N+2 with rdata 0x8877_6655.
- Load signed byte addr 0x13 with mem[4]=0x8877_6655 → rdata 0xFFFF_FF88. Same access unsigned → 0x0000_0088.
- Store byte 0xAB to addr 0x21 with mem[8]=0x1122_3344 → single dmem_we pulse at N+1, wdata 0x1122_AB44, resp_valid N+2.
- Store half 0xBEEF to addr 0x22, then load word → 0xBEEF_xxxx, low half unchanged.
- resp_ready held 0 for 5 cycles → resp fields stable, req_ready=0; request accepted the cycle after the resp_ready handshake.
- With DMEM_MISALIGN_CHK_EN, word store to 0x06 → no dmem_we, resp_err=1 at N+1. Without the macro → write to word 1.
- reset_n pulse low during RMW_WR → no dmem_we pulse, all outputs at reset values.
